// File: rtl/input_conditioner.sv
// Input front-end for the combination-lock FSM: synchronises, debounces and pulse-shapes buttons and data switches.
// Optional build macro BTN_AUTOREPEAT_EN adds auto-repeat of the set-data pulse while the set button is held.
module input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DATA_W          = 4,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic              clk,
  input  logic              i_Rst,
  input  logic              i_btn_ce,
  input  logic              i_btn_set,
  input  logic [DATA_W-1:0] iv_sw_data,
  output logic              o_CE,
  output logic              o_set_data,
  output logic [DATA_W-1:0] ov_data,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {RELEASED = 1'b0, PRESSED = 1'b1} btn_state_t;

  logic [SYNC_STAGES-1:0] ce_sync;
  logic [SYNC_STAGES-1:0] set_sync;
  logic [DATA_W-1:0]      data_sync [SYNC_STAGES];

  logic [1:0]        btn_s;
  logic [DATA_W-1:0] data_s;

  btn_state_t        btn_state  [2];
  logic [CNT_W-1:0]  btn_cnt    [2];
  logic [1:0]        btn_toggle;
  logic [1:0]        btn_press;

  logic [DATA_W-1:0] data_prev;
  logic [CNT_W-1:0]  data_cnt;
  logic              data_load;
  logic              pending;
  logic              set_req;
  logic              rep_fire;

  // Plain flop chains only; nothing else may sit on these paths.
  always_ff @(posedge clk) begin
    if (i_Rst) begin
      ce_sync  <= '0;
      set_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync[i] <= '0;
    end else begin
      ce_sync      <= {ce_sync[SYNC_STAGES-2:0], i_btn_ce};
      set_sync     <= {set_sync[SYNC_STAGES-2:0], i_btn_set};
      data_sync[0] <= iv_sw_data;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync[i] <= data_sync[i-1];
    end
  end

  assign btn_s  = {set_sync[SYNC_STAGES-1], ce_sync[SYNC_STAGES-1]};
  assign data_s = data_sync[SYNC_STAGES-1];

  // Index 0 is the CE button, index 1 the set-data button.
  always_comb begin
    btn_toggle = '0;
    btn_press  = '0;
    for (int i = 0; i < 2; i++) begin
      btn_toggle[i] = (btn_s[i] != (btn_state[i] == PRESSED)) && (btn_cnt[i] == CNT_LAST);
      btn_press[i]  = btn_toggle[i] && (btn_state[i] == RELEASED);
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  logic [REP_W-1:0] rep_cnt;

  assign rep_fire = (btn_state[1] == PRESSED) && !btn_toggle[1] &&
                    (rep_cnt == REP_W'(REPEAT_CYCLES - 1));

  // Restarts on every new press so repeats are spaced from the initial pulse.
  always_ff @(posedge clk) begin
    if (i_Rst || btn_state[1] != PRESSED || btn_toggle[1] || rep_fire) rep_cnt <= '0;
    else rep_cnt <= rep_cnt + 1'b1;
  end
`else
  assign rep_fire = 1'b0 & (REPEAT_CYCLES > 0);
`endif

  assign set_req   = btn_press[1] || pending || rep_fire;
  assign data_load = (data_cnt == CNT_MAX) && (data_s == data_prev) &&
                     (btn_state[1] != PRESSED) && !o_set_data;

  always_ff @(posedge clk) begin
    if (i_Rst) begin
      for (int i = 0; i < 2; i++) begin
        btn_state[i] <= RELEASED;
        btn_cnt[i]   <= '0;
      end
      data_prev  <= '0;
      data_cnt   <= '0;
      pending    <= 1'b0;
      o_CE       <= 1'b0;
      o_set_data <= 1'b0;
      ov_data    <= '0;
      o_busy     <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_toggle[i]) begin
          btn_state[i] <= (btn_state[i] == PRESSED) ? RELEASED : PRESSED;
          btn_cnt[i]   <= '0;
        end else if (btn_s[i] != (btn_state[i] == PRESSED)) begin
          btn_cnt[i] <= btn_cnt[i] + 1'b1;
        end else begin
          btn_cnt[i] <= '0;
        end
      end

      // A set request that coincides with a CE pulse slips one cycle.
      if (btn_press[0]) begin
        o_CE       <= 1'b1;
        o_set_data <= 1'b0;
        pending    <= set_req;
      end else begin
        o_CE       <= 1'b0;
        o_set_data <= set_req;
        pending    <= 1'b0;
      end

      data_prev <= data_s;
      if (data_s != data_prev) data_cnt <= '0;
      else if (data_cnt != CNT_MAX) data_cnt <= data_cnt + 1'b1;
      if (data_load) ov_data <= data_s;

      o_busy <= (btn_cnt[0] != '0) || (btn_cnt[1] != '0) || (data_cnt != '0);
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8).
// The auto-repeat scenario is only exercised when BTN_AUTOREPEAT_EN is defined.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       i_Rst;
  logic       i_btn_ce;
  logic       i_btn_set;
  logic [3:0] iv_sw_data;
  logic       o_CE;
  logic       o_set_data;
  logic [3:0] ov_data;
  logic       o_busy;

  int tests  = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    bit         is_set;
    int         cycle;
    bit         chk_data;
    logic [3:0] data;
  } exp_t;

  exp_t expq[$];

  input_conditioner #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .DATA_W(4), .REPEAT_CYCLES(8)
  ) dut (
    .clk(clk), .i_Rst(i_Rst), .i_btn_ce(i_btn_ce), .i_btn_set(i_btn_set),
    .iv_sw_data(iv_sw_data), .o_CE(o_CE), .o_set_data(o_set_data),
    .ov_data(ov_data), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // After posedge n, cyc reads n for the following half period.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic ce, input logic set, input logic [3:0] sw);
    i_btn_ce   = ce;
    i_btn_set  = set;
    iv_sw_data = sw;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    tests++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushExp(input bit is_set, input int cycle, input bit chk, input logic [3:0] d);
    exp_t e;
    e.is_set = is_set; e.cycle = cycle; e.chk_data = chk; e.data = d;
    expq.push_back(e);
  endtask

  task automatic handlePulse(input bit is_set);
    exp_t e;
    tests++;
    if (expq.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_pulse: got %s at cycle %0d, expected none", is_set ? "o_set_data" : "o_CE", cyc);
    end else begin
      e = expq.pop_front();
      if (e.is_set != is_set || e.cycle != cyc) begin
        errors++;
        $display("[TB] FAIL pulse_order: got %s at cycle %0d, expected %s at cycle %0d",
                 is_set ? "o_set_data" : "o_CE", cyc, e.is_set ? "o_set_data" : "o_CE", e.cycle);
      end else if (e.chk_data) begin
        checkOutput("ov_data_at_set", ov_data, e.data);
      end
    end
  endtask

  // Monitor: consumes one scoreboard entry per observed pulse.
  always @(negedge clk) begin
    if (o_CE === 1'b1 && o_set_data === 1'b1) begin
      tests++;
      errors++;
      $display("[TB] FAIL pulse_overlap: got o_CE=1 o_set_data=1 at cycle %0d, expected never both", cyc);
    end
    if (o_CE === 1'b1) handlePulse(1'b0);
    if (o_set_data === 1'b1) handlePulse(1'b1);
  end

  initial begin
    int c;
    i_Rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 4'hF);

    // Reset held three cycles with every input high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_o_CE", {3'b0, o_CE}, 4'h0);
      checkOutput("rst_o_set_data", {3'b0, o_set_data}, 4'h0);
      checkOutput("rst_ov_data", ov_data, 4'h0);
      checkOutput("rst_o_busy", {3'b0, o_busy}, 4'h0);
    end
    i_Rst = 1'b0;
    pushExp(1'b0, cyc + 6, 1'b0, 4'h0);
    pushExp(1'b1, cyc + 7, 1'b0, 4'h0);
    waitCycles(15);
    applyStimulus(1'b0, 1'b0, 4'hF);
    waitCycles(12);
    checkOutput("post_reset_ov_data", ov_data, 4'hF);

    // Clean presses, each held long enough to prove there is only one pulse.
    for (int p = 0; p < 2; p++) begin
      applyStimulus(1'b1, 1'b0, 4'hF);
      pushExp(1'b0, cyc + 6, 1'b0, 4'h0);
      waitCycles(20);
      applyStimulus(1'b0, 1'b0, 4'hF);
      waitCycles(12);
    end

    // Bouncing set button: 1,0,1,0 then steady 1.
    c = cyc;
    applyStimulus(1'b0, 1'b1, 4'hF); waitCycles(1);
    applyStimulus(1'b0, 1'b0, 4'hF); waitCycles(1);
    applyStimulus(1'b0, 1'b1, 4'hF); waitCycles(1);
    applyStimulus(1'b0, 1'b0, 4'hF); waitCycles(1);
    applyStimulus(1'b0, 1'b1, 4'hF);
    pushExp(1'b1, c + 10, 1'b1, 4'hF);
    waitCycles(20);
    applyStimulus(1'b0, 1'b0, 4'hF);
    waitCycles(12);

    // Data nibble loads when stable and is frozen while set is held.
    applyStimulus(1'b0, 1'b0, 4'hA);
    waitCycles(10);
    checkOutput("data_A_loaded", ov_data, 4'hA);
    applyStimulus(1'b0, 1'b1, 4'hA);
    pushExp(1'b1, cyc + 6, 1'b1, 4'hA);
    waitCycles(8);
    applyStimulus(1'b0, 1'b1, 4'h5);
    waitCycles(12);
    checkOutput("data_frozen_while_pressed", ov_data, 4'hA);
    applyStimulus(1'b0, 1'b0, 4'h5);
    waitCycles(10);
    checkOutput("data_5_after_release", ov_data, 4'h5);

    // Simultaneous acceptance defers set-data by one cycle.
    applyStimulus(1'b1, 1'b1, 4'h5);
    pushExp(1'b0, cyc + 6, 1'b0, 4'h0);
    pushExp(1'b1, cyc + 7, 1'b1, 4'h5);
    waitCycles(20);
    applyStimulus(1'b0, 1'b0, 4'h5);
    waitCycles(12);

    // Reset mid-debounce discards the partial count; debounce restarts afterwards.
    c = cyc;
    applyStimulus(1'b1, 1'b0, 4'h5);
    waitCycles(3);
    i_Rst = 1'b1;
    waitCycles(1);
    checkOutput("midrst_o_CE", {3'b0, o_CE}, 4'h0);
    checkOutput("midrst_o_busy", {3'b0, o_busy}, 4'h0);
    checkOutput("midrst_ov_data", ov_data, 4'h0);
    i_Rst = 1'b0;
    pushExp(1'b0, c + 10, 1'b0, 4'h0);
    waitCycles(20);
    applyStimulus(1'b0, 1'b0, 4'h5);
    waitCycles(12);
    checkOutput("data_reload_after_rst", ov_data, 4'h5);

`ifdef BTN_AUTOREPEAT_EN
    // Held set button repeats every 8 cycles until the debounced release.
    c = cyc;
    applyStimulus(1'b0, 1'b1, 4'h5);
    pushExp(1'b1, c + 6, 1'b1, 4'h5);
    pushExp(1'b1, c + 14, 1'b1, 4'h5);
    pushExp(1'b1, c + 22, 1'b1, 4'h5);
    pushExp(1'b1, c + 30, 1'b1, 4'h5);
    waitCycles(26);
    applyStimulus(1'b0, 1'b0, 4'h5);
    waitCycles(30);
`endif

    waitCycles(5);
    tests++;
    if (expq.size() != 0) begin
      errors++;
      $display("[TB] FAIL missing_pulses: got %0d outstanding expected pulses, expected 0", expq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Upstream front-end for the combination-lock FSM. Conditions the raw switch and button inputs before the FSM sees them.
- Synchronises and debounces two push-buttons (clock-enable, set-data) and the 4-bit data switch bank.
- Emits single-cycle pulses o_CE / o_set_data and a glitch-free nibble ov_data that connect directly to the FSM's i_CE, i_set_data and iv_data.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser (minimum 2).
- DEBOUNCE_CYCLES, 16, consecutive identical synchronised samples required to accept a new level (minimum 2).
- DATA_W, 4, width of the data switch bank.
- REPEAT_CYCLES, 64, auto-repeat period; used only when BTN_AUTOREPEAT_EN is defined.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- i_Rst  in  1  synchronous, active-high reset.
- i_btn_ce  in  1  raw, asynchronous, bouncing clock-enable button.
- i_btn_set  in  1  raw, asynchronous, bouncing set-data button.
- iv_sw_data  in  DATA_W  raw, asynchronous data switches.
- o_CE  out  1  one-cycle pulse per accepted press of i_btn_ce.
- o_set_data  out  1  one-cycle pulse per accepted press of i_btn_set.
- ov_data  out  DATA_W  debounced data nibble; stable whenever o_set_data is high.
- o_busy  out  1  high while any channel's debounce counter is non-zero.

Behaviour:
- Reset (i_Rst high at a clock edge):
  - Synchroniser flops, debounced levels, counters, pending flag and all outputs clear to 0.
  - Reset has priority over all other activity. Asserting it mid-debounce discards the partial count; no pulse is produced.
- Synchroniser: each raw bit passes through a chain of SYNC_STAGES flops. No other logic is allowed on these paths.
- Per-button channel, 2-state FSM with a counter (width ceil(log2(DEBOUNCE_CYCLES+1))):
  - States are RELEASED (debounced level 0) and PRESSED (debounced level 1).
  - When the synchronised sample differs from the debounced level, the counter increments. When it equals the debounced level, the counter clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles, the state changes and the counter clears, all on the same edge.
  - A RELEASED->PRESSED transition raises that channel's pulse for exactly one cycle, on the same edge as the toggle. PRESSED->RELEASED produces no pulse.
  - Latency: a raw level held stable from edge k produces its pulse in the cycle after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1 (6 cycles for SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
  - Bounce shorter than DEBOUNCE_CYCLES resets the count and produces no pulse.
- Data channel:
  - One shared counter for the whole DATA_W vector. Any bit of the synchronised vector differing from the previous sample clears it.
  - When the vector has been unchanged for DEBOUNCE_CYCLES cycles, it loads into ov_data.
  - ov_data is frozen while the set channel is PRESSED and during the o_set_data pulse cycle; loads are suppressed and taken after release.
  - Counter saturates at DEBOUNCE_CYCLES; no wrap.
- Simultaneous acceptance: if the CE and set channels toggle to PRESSED on the same edge, o_CE pulses that cycle and o_set_data is deferred via a pending flag to the next cycle. o_CE and o_set_data are never high together.
- Held buttons produce exactly one pulse per press (unless BTN_AUTOREPEAT_EN is defined).
- o_busy = OR of the three counters being non-zero; registered, so it updates one cycle after the counters.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - While the set channel remains PRESSED, a repeat counter runs. o_set_data re-pulses every REPEAT_CYCLES cycles after the initial pulse (initial at cycle t, repeats at t+REPEAT_CYCLES, t+2*REPEAT_CYCLES, ...).
  - Release clears the repeat counter.
  - A repeat pulse colliding with an o_CE pulse is deferred one cycle, as in the simultaneous-acceptance rule.
- Undefined: no repeat counter is synthesised and REPEAT_CYCLES is ignored.

Test Plan:
(All with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.)
- Reset: hold i_Rst 3 cycles with all inputs 1 -> o_CE=0, o_set_data=0, ov_data=0, o_busy=0 during reset. After release, exactly one o_CE and one o_set_data pulse occur; they are not simultaneous (deferral).
- Clean press: i_btn_ce 0->1 at edge 10 and held -> o_CE high only in the cycle after edge 15. Releasing and pressing again -> second single pulse.
- Bounce: i_btn_set toggles 1,0,1,0 at 1-cycle intervals, then stays 1 -> no pulse during bounce; one o_set_data pulse 6 cycles after the last rising toggle.
- Data stability: iv_sw_data=4'hA held 10 cycles -> ov_data=4'hA. Switch to 4'h5 while set is PRESSED -> ov_data stays 4'hA until the set channel is RELEASED, then becomes 4'h5.
- Simultaneous press: i_btn_ce and i_btn_set rise on the same edge -> o_CE pulses at cycle N and o_set_data at N+1, never overlapping.
- BTN_AUTOREPEAT_EN defined, REPEAT_CYCLES=8: hold i_btn_set 30 cycles after acceptance -> pulses at t, t+8, t+16, t+24; none after release.
